// File: rtl/pong_pkg.sv
// Shared definitions for the Pong match controller.
//   - FSM state encodings (exposed on the state output for display/debug)
//   - playfield rows used for miss detection and the ball's centre position
//   - winner codes
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [5:0] TOP_ROW    = 6'd0;
    localparam logic [5:0] BOTTOM_ROW = 6'd63;

    // Where the ball block re-centres while ball_hold is high.
    localparam logic [6:0] BALL_X0 = 7'd64;
    localparam logic [5:0] BALL_Y0 = 6'd32;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Match-controller signal bundle.
//   start     : start button level (synchronised, debounced)
//   ballY     : current ball row from the ball block
//   ball_hold : 1 = ball held at centre (drives the ball block's reset)
//   score1    : bottom-player score
//   score2    : top-player score
//   winner    : 0 none, 1 bottom player, 2 top player
//   state     : current FSM state
// master = the environment (button + ball block), slave = the controller.
interface pong_match_ctrl_if;
    logic       start;
    logic [5:0] ballY;
    logic       ball_hold;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [1:0] winner;
    logic [2:0] state;

    modport master (
        output start, ballY,
        input  ball_hold, score1, score2, winner, state
    );

    modport slave (
        input  start, ballY,
        output ball_hold, score1, score2, winner, state
    );
endinterface

// File: rtl/pause_timer.sv
// Loadable down-counter used for the serve and post-point pauses.
//   clk, rst : clock, async active-high reset (count clears to 0)
//   load     : load count with load_val (takes priority over decrement)
//   load_val : value to load
//   done     : count == 0; the counter holds at zero
module pause_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign done = (count == '0);
endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: holds the ball at centre, releases it for a rally,
// detects misses at the top/bottom rows, keeps score and declares a winner.
//   clk, rst : system clock, async active-high reset
//   bus      : pong_match_ctrl_if.slave (start, ballY in; ball_hold,
//              score1, score2, winner, state out)
//
//   state | meaning
//   IDLE  | waiting for first start, ball held
//   SERVE | pre-serve pause, SERVE_CYC cycles, ball held
//   PLAY  | rally, ball released, misses scored
//   POINT | post-point pause, POINT_CYC cycles, ball held
//   OVER  | match won, scores frozen until next start
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int CLK_HZ    = 10_000_000,
    parameter int SERVE_MS  = 1000,
    parameter int POINT_MS  = 500,
    parameter int WIN_SCORE = 7
) (
    input  logic               clk,
    input  logic               rst,
    pong_match_ctrl_if.slave   bus
);
    localparam int SERVE_CYC = CLK_HZ / 1000 * SERVE_MS;
    localparam int POINT_CYC = CLK_HZ / 1000 * POINT_MS;
    localparam int TW        = $clog2(max_int(SERVE_CYC, POINT_CYC) + 1);

    localparam logic [TW-1:0] SERVE_LOAD = TW'(SERVE_CYC - 1);
    localparam logic [TW-1:0] POINT_LOAD = TW'(POINT_CYC - 1);
    localparam logic [3:0]    WIN_VAL    = 4'(WIN_SCORE);

    state_t        state_q, state_n;
    logic          hold_q;
    logic [3:0]    score1_q, score1_n;
    logic [3:0]    score2_q, score2_n;
    logic [1:0]    winner_q, winner_n;
    logic          start_q;
    logic          start_pulse;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;

    assign start_pulse = bus.start & ~start_q;

    pause_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            hold_q   <= 1'b1;
            score1_q <= '0;
            score2_q <= '0;
            winner_q <= WIN_NONE;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_n;
            // Registered from next state so the ball is released on the
            // very first PLAY cycle and held again on the first POINT cycle.
            hold_q   <= (state_n != ST_PLAY);
            score1_q <= score1_n;
            score2_q <= score2_n;
            winner_q <= winner_n;
            start_q  <= bus.start;
        end
    end

    always_comb begin
        state_n  = state_q;
        score1_n = score1_q;
        score2_n = score2_q;
        winner_n = winner_q;
        tmr_load = 1'b0;
        tmr_val  = SERVE_LOAD;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_pulse) begin
                    score1_n = '0;
                    score2_n = '0;
                    winner_n = WIN_NONE;
                    tmr_load = 1'b1;
                    tmr_val  = SERVE_LOAD;
                    state_n  = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (tmr_done)
                    state_n = ST_PLAY;
            end
            ST_PLAY: begin
                // Top row checked first so an impossible both-rows code
                // still resolves deterministically.
                if (bus.ballY == TOP_ROW) begin
                    score1_n = score1_q + 4'd1;
                    if (score1_n == WIN_VAL) begin
                        winner_n = WIN_P1;
                        state_n  = ST_OVER;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = POINT_LOAD;
                        state_n  = ST_POINT;
                    end
                end else if (bus.ballY == BOTTOM_ROW) begin
                    score2_n = score2_q + 4'd1;
                    if (score2_n == WIN_VAL) begin
                        winner_n = WIN_P2;
                        state_n  = ST_OVER;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = POINT_LOAD;
                        state_n  = ST_POINT;
                    end
                end
            end
            ST_POINT: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = SERVE_LOAD;
                    state_n  = ST_SERVE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.state     = state_q;
    assign bus.ball_hold = hold_q;
    assign bus.score1    = score1_q;
    assign bus.score2    = score2_q;
    assign bus.winner    = winner_q;
endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
- Match sequencer for the Pong datapath: holds the ball at centre, releases it for a rally, detects misses at the top/bottom rows, keeps score and declares a winner.
- Sits between the start button and the ball block; its ball_hold output drives the ball block's reset input, so the ball re-centres at (64,32) whenever it is held.

Parameters:
- CLK_HZ, 10_000_000, system clock frequency in Hz.
- SERVE_MS, 1000, pre-serve pause in ms; SERVE_CYC = CLK_HZ/1000*SERVE_MS cycles.
- POINT_MS, 500, post-point pause in ms; POINT_CYC = CLK_HZ/1000*POINT_MS cycles.
- WIN_SCORE, 7, points needed to win; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  start button, already synchronised and debounced, level.
- ballY  in  6  current ball row from the ball block.
- ball_hold  out  1  registered; 1 = ball held at centre (drives the ball block's rst).
- score1  out  4  bottom-player score.
- score2  out  4  top-player score.
- winner  out  2  0 none, 1 bottom player, 2 top player.
- state  out  3  current FSM state, for display and debug.

Behaviour:
- Reset (async, any time, including mid-rally): state=IDLE, ball_hold=1, score1=score2=0, winner=0, timer=0, start_q=0.
- Start edge: start_pulse = start & ~start_q. start_q is registered every cycle. Start edges in SERVE, PLAY and POINT are ignored.
- States and encodings: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4. Values 5..7 are illegal and go to IDLE on the next clock.
- IDLE: ball_hold=1.
  - On start_pulse: clear scores, clear winner, load timer with SERVE_CYC-1, go to SERVE.
- SERVE: ball_hold=1, timer decrements each cycle.
  - When timer==0, go to PLAY.
  - state==SERVE for exactly SERVE_CYC cycles.
- PLAY: ball_hold=0, registered, so low on the first PLAY cycle.
  - Miss detect, sampled each cycle: ballY==0 is a top miss (score1+1); ballY==63 is a bottom miss (score2+1).
  - Both cannot occur in one cycle; if encoded so, top miss has priority.
  - On a miss, the updated score equals WIN_SCORE: set winner (1 or 2), go to OVER.
  - Otherwise: load timer with POINT_CYC-1, go to POINT.
  - Score and next state update on the same edge, so there is 1-cycle latency from ballY hitting the row to the score change.
- POINT: ball_hold=1, which re-centres the ball on the next clock.
  - Counts POINT_CYC cycles, then loads timer with SERVE_CYC-1 and goes to SERVE.
  - Miss detect is disabled here.
- OVER: ball_hold=1; scores and winner frozen.
  - On start_pulse: clear scores and winner, load timer with SERVE_CYC-1, go to SERVE.
- Arithmetic and widths:
  - Scores are 4-bit unsigned and never exceed WIN_SCORE; no wrap is possible.
  - Timer width is $clog2(max(SERVE_CYC,POINT_CYC)+1).
  - SERVE_CYC and POINT_CYC must be >=1; a value of 1 gives a single-cycle state.
- Held start: a start held high across reset release produces exactly one pulse on the first clock after reset, because start_q resets to 0.

Decomposition:
- Shared package pong_pkg:
  - state encodings ST_IDLE..ST_OVER;
  - TOP_ROW=0, BOTTOM_ROW=63;
  - BALL_X0=64, BALL_Y0=32;
  - WIN_NONE/WIN_P1/WIN_P2 codes.
- One sub-module, pause_timer: loadable down-counter with inputs load and load_val, output done (count==0), and async active-high reset.
- FSM, scoring and start-edge logic stay in pong_match_ctrl.

Test Plan:
All scenarios use CLK_HZ=1000, SERVE_MS=4, POINT_MS=3, WIN_SCORE=3.
- Reset then idle: rst=1 for 2 cycles, release, start=0 for 10 cycles -> state=0, ball_hold=1, scores 0/0, winner=0 throughout.
- Serve timing: start pulse -> state=1 for exactly 4 cycles, then state=2 and ball_hold=0 on the same edge.
- Score bottom: in PLAY drive ballY=0 -> next edge score1=1, state=3, ball_hold=1. After 3 cycles state=1; after 4 more cycles state=2.
- Match win: three ballY=63 misses in PLAY -> on the third, score2=3, winner=2, state=4. Start held high afterwards -> exactly one restart to SERVE with scores 0/0.
- Ignored inputs: start toggled during SERVE/PLAY/POINT -> no state change. ballY=0 during POINT -> score unchanged.
- Async reset mid-rally: rst asserted between clock edges in PLAY with score1=2 -> outputs immediately return to IDLE values (score1=0, ball_hold=1) before the next edge.
